seg_data_mux: RTL and testbench
===============================

Name: seg_data_mux

Overview:
- Downstream of the digit-scan counter; consumes its 2-bit digit index `i_ctrl` and drives the shared segment bus of a 4-digit 7-segment display.
- Accepts a 16-bit hex value through a valid/ready handshake and commits it only at a scan-frame boundary, so a digit is never torn mid-frame.
- Decodes the selected nibble and applies leading-zero suppression, per-digit blink, decimal points and an anti-ghosting blank window after every digit change.

Parameters:
- BLANK_CYCLES, 2, number of clocks the segments are forced off after each `i_ctrl` change (0 = no blanking).
- BLINK_FRAMES, 64, number of scan frames per blink half-period; must be ≥ 1.
- SEG_ACTIVE_LOW, 1, polarity of `o_seg` and `o_dp`: 1 = a lit segment is driven 0.

Ports:
- i_clk  in  1  system clock; one clock domain.
- i_rst  in  1  synchronous, active-high reset.
- i_ctrl  in  2  digit index from the scan counter; 0 = rightmost digit = nibble [3:0], 3 = nibble [15:12].
- i_value  in  16  hex value to display.
- i_valid  in  1  `i_value` is offered.
- o_ready  out  1  the pending slot is empty; a transfer occurs when `i_valid && o_ready`.
- i_dp  in  4  decimal-point enable per digit.
- i_blink  in  4  blink enable per digit.
- i_lz_en  in  1  enables leading-zero suppression.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, registered.
- o_dp  out  1  decimal point for the current digit, registered.

Behaviour:

Reset (while `i_rst` is high):
- `o_seg` = all off (7'h7F when active-low), `o_dp` = off, `o_ready` = 0.
- `ctrl_q` = 0, display register = 16'h0000, pending slot empty, blank counter = 0, frame counter = 0, blink phase = 0.
- `o_ready` goes to 1 on the first clock after `i_rst` is released.
- Reset asserted mid-operation discards any pending value and any blank window; there is no other effect.

Handshake:
- `o_ready` is registered and equals NOT pending_full.
- On the transfer cycle: pending <= `i_value`, pending_full <= 1, and `o_ready` falls on the next cycle.
- `i_value` is ignored whenever `o_ready` is 0. There is no back-to-back acceptance while a value is pending.

Frame boundary:
- A frame boundary is the cycle on which `i_ctrl` == 0 and `ctrl_q` == 3.
- At a boundary with pending_full: display <= pending and pending_full <= 0, so `o_ready` returns to 1 one cycle later.
- At a boundary without pending_full, the display register holds.

Digit change and anti-ghosting:
- Each cycle on which `i_ctrl` != `ctrl_q` (cycle N): `ctrl_q` <= `i_ctrl` and blank counter <= BLANK_CYCLES.
- While the blank counter is nonzero: outputs are off and the counter decrements by one per cycle.
- Result: cycles N+1 .. N+BLANK_CYCLES show blank, and cycle N+BLANK_CYCLES+1 shows digit `ctrl_q`.
- With BLANK_CYCLES = 0 the new digit appears at N+1.
- If `i_ctrl` changes again during a window, the counter reloads.
- The blank counter width is clog2(BLANK_CYCLES+1).

Output decode for digit k = `ctrl_q`, outside the blank window (registered, 1-cycle latency):
- Segments: standard hex decode of nibble k (0-9, A, b, C, d, E, F).
- Leading-zero suppression: when `i_lz_en` = 1, k > 0 and nibbles k..3 are all zero, the segments are off. Digit 0 is never suppressed. `o_dp` is not affected by suppression.
- Blink: when blink phase = 1 and `i_blink`[k] = 1, both the segments and `o_dp` are off.
- Decimal point: otherwise `o_dp` = `i_dp`[k].
- Polarity: when SEG_ACTIVE_LOW = 1, the final values are inverted.

Blink timer:
- The frame counter increments on each frame boundary.
- When the counter equals BLINK_FRAMES-1 at a boundary, it wraps to 0 and the blink phase toggles.

Simultaneous events:
- A transfer and a frame boundary cannot coincide in a way that loses data, because `o_ready` is 0 whenever pending_full is 1.
- A digit change and a frame boundary in the same cycle: the new display value is used for the digit shown after the blank window.

Test Plan:
1. Reset, then send `i_value` = 16'h00A1 with `i_lz_en` = 1, and scan `i_ctrl` 0,1,2,3 holding each value 10 cycles (BLANK_CYCLES = 2, SEG_ACTIVE_LOW = 1) -> before the next frame boundary every digit shows 7'h7F, except digit 0 which shows 7'h40 ('0'). After the boundary: digit 0 = 7'h79 ('1'), digit 1 = 7'h08 ('A'), digits 2-3 = 7'h7F.
2. Blank window: step `i_ctrl` 0->1 at cycle N -> `o_seg` = 7'h7F at N+1 and N+2, and the digit-1 pattern at N+3. Toggling `i_ctrl` 1->2->1 within the window restarts the full 2-cycle blank.
3. Handshake: with pending_full, hold `i_valid` = 1 and change `i_value` each cycle -> `o_ready` stays 0 and only the first value is displayed. `o_ready` returns to 1 exactly one cycle after the frame boundary.
4. Blink: `i_blink` = 4'b0010, `i_dp` = 4'b0010, BLINK_FRAMES = 2 -> digit 1 (segments and dp) is off for 2 frames, then on for 2 frames, alternating. Digits 0, 2 and 3 are unaffected.
5. Leading-zero suppression off: `i_lz_en` = 0 with value 16'h0000 -> all four digits show 7'h40.
6. Reset mid-frame with a pending value -> outputs go off and `o_ready` = 0 during reset. After release, 16'h0000 is displayed, the old pending value never appears, and `o_ready` = 1 on the first clock after release.

Source files
------------

// File: rtl/seg_data_mux.sv
// Segment data path for a 4-digit 7-segment display: takes a handshaked hex value,
// commits it at scan-frame boundaries, and drives decoded, blanked and blinking segments.
module seg_data_mux #(
  parameter int BLANK_CYCLES   = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_ctrl,
  input  logic [15:0] i_value,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_blink,
  input  logic        i_lz_en,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [1:0]    ctrl_q;
  logic [BW-1:0] blank_cnt;
  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic [15:0]   pending;
  logic          pending_full;
  logic [15:0]   display;

  logic          digit_change;
  logic          boundary;
  logic          transfer;
  logic          pending_full_next;
  logic [3:0]    nibble;
  logic          lead_zero;
  logic [6:0]    seg_lit;
  logic          dp_lit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign digit_change = (i_ctrl != ctrl_q);
  assign boundary     = (i_ctrl == 2'd0) && (ctrl_q == 2'd3);
  assign transfer     = i_valid && o_ready;

  // o_ready tracks the next pending state so it drops right after the transfer edge.
  always_comb begin
    pending_full_next = pending_full;
    if (boundary && pending_full) pending_full_next = 1'b0;
    else if (transfer)            pending_full_next = 1'b1;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nibble    = display[{ctrl_q, 2'b00} +: 4];
    lead_zero = 1'b0;
    case (ctrl_q)
      2'd1:    lead_zero = (display[15:4]  == 12'h000);
      2'd2:    lead_zero = (display[15:8]  == 8'h00);
      2'd3:    lead_zero = (display[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase

    seg_lit = hex7(nibble);
    dp_lit  = i_dp[ctrl_q];
    if (i_lz_en && lead_zero) seg_lit = 7'h00;
    if (blink_phase && i_blink[ctrl_q]) begin
      seg_lit = 7'h00;
      dp_lit  = 1'b0;
    end
    if (blank_cnt != '0) begin
      seg_lit = 7'h00;
      dp_lit  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ctrl_q       <= 2'd0;
      blank_cnt    <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      pending      <= 16'h0000;
      pending_full <= 1'b0;
      display      <= 16'h0000;
      o_ready      <= 1'b0;
      o_seg        <= SEG_OFF;
      o_dp         <= SEG_ACTIVE_LOW;
    end else begin
      if (digit_change) begin
        ctrl_q    <= i_ctrl;
        blank_cnt <= BLANK_LOAD;
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end

      if (boundary) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        if (pending_full) display <= pending;
      end

      if (transfer) pending <= i_value;
      pending_full <= pending_full_next;
      o_ready      <= ~pending_full_next;

      o_seg <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      o_dp  <= SEG_ACTIVE_LOW ? ~dp_lit  : dp_lit;
    end
  end

endmodule

// File: tb/tb_seg_data_mux.sv
// Directed bench for seg_data_mux: vector table for the decode path plus hand-written
// sequences for handshake, blank window, blink and reset corner cases.
module tb_seg_data_mux;

  localparam logic [6:0] OFF = 7'h7F;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_ctrl = 2'd0;
  logic [15:0] i_value = 16'h0000;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_dp = 4'h0;
  logic [3:0]  i_blink = 4'h0;
  logic        i_lz_en = 1'b0;
  logic [6:0]  o_seg;
  logic        o_dp;

  int n_checks = 0;
  int n_pass   = 0;

  seg_data_mux #(
    .BLANK_CYCLES  (2),
    .BLINK_FRAMES  (2),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_ctrl (i_ctrl),
    .i_value(i_value),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_dp   (i_dp),
    .i_blink(i_blink),
    .i_lz_en(i_lz_en),
    .o_seg  (o_seg),
    .o_dp   (o_dp)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  dp;
    logic [1:0]  ctrl;
    logic [6:0]  seg;
    logic        odp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic hold(input logic [1:0] c, input int n);
    i_ctrl = c;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ctrl  = 2'd0;
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  // Waits (bounded) for o_ready, then performs one transfer.
  task automatic send(input logic [15:0] v);
    for (int i = 0; i < 50 && !o_ready; i++) tick();
    check("send_ready", 16'(o_ready), 16'd1);
    i_valid = 1'b1;
    i_value = v;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic load_value(input logic [15:0] v);
    send(v);
    hold(2'd1, 1);
    hold(2'd2, 1);
    hold(2'd3, 1);
    hold(2'd0, 1);
  endtask

  initial begin
    logic [15:0] loaded;
    logic        phase;

    vecs[0]  = '{16'h0000, 1'b0, 4'b0000, 2'd0, 7'h40, 1'b1};
    vecs[1]  = '{16'h0000, 1'b0, 4'b0000, 2'd1, 7'h40, 1'b1};
    vecs[2]  = '{16'h0000, 1'b0, 4'b0000, 2'd2, 7'h40, 1'b1};
    vecs[3]  = '{16'h0000, 1'b0, 4'b0000, 2'd3, 7'h40, 1'b1};
    vecs[4]  = '{16'h0000, 1'b1, 4'b0000, 2'd3, OFF,   1'b1};
    vecs[5]  = '{16'h0000, 1'b1, 4'b0000, 2'd0, 7'h40, 1'b1};
    vecs[6]  = '{16'hBEEF, 1'b1, 4'b0100, 2'd2, 7'h06, 1'b0};
    vecs[7]  = '{16'hBEEF, 1'b1, 4'b0100, 2'd3, 7'h03, 1'b1};
    vecs[8]  = '{16'hBEEF, 1'b1, 4'b0100, 2'd1, 7'h06, 1'b1};
    vecs[9]  = '{16'hBEEF, 1'b1, 4'b0100, 2'd0, 7'h0E, 1'b1};
    vecs[10] = '{16'h0C0D, 1'b1, 4'b0000, 2'd1, 7'h40, 1'b1};
    vecs[11] = '{16'h0C0D, 1'b1, 4'b0000, 2'd3, OFF,   1'b1};
    vecs[12] = '{16'h0C0D, 1'b1, 4'b0000, 2'd2, 7'h46, 1'b1};
    vecs[13] = '{16'h0C0D, 1'b1, 4'b0000, 2'd0, 7'h21, 1'b1};
    vecs[14] = '{16'h0050, 1'b1, 4'b1000, 2'd3, OFF,   1'b0};
    vecs[15] = '{16'h0050, 1'b1, 4'b1000, 2'd2, OFF,   1'b1};
    vecs[16] = '{16'h7896, 1'b0, 4'b0000, 2'd0, 7'h02, 1'b1};
    vecs[17] = '{16'h7896, 1'b0, 4'b0000, 2'd3, 7'h78, 1'b1};

    // Reset state and first ready
    tick();
    tick();
    check("rst_seg", 16'(o_seg), 16'(OFF));
    check("rst_dp", 16'(o_dp), 16'd1);
    check("rst_ready", 16'(o_ready), 16'd0);
    i_rst = 1'b0;
    tick();
    check("ready_after_release", 16'(o_ready), 16'd1);

    // Value commits only at the frame boundary
    i_lz_en = 1'b1;
    send(16'h00A1);
    check("ready_after_transfer", 16'(o_ready), 16'd0);
    hold(2'd0, 10); check("pre_d0", 16'(o_seg), 16'h40);
    hold(2'd1, 10); check("pre_d1", 16'(o_seg), 16'(OFF));
    hold(2'd2, 10); check("pre_d2", 16'(o_seg), 16'(OFF));
    hold(2'd3, 10); check("pre_d3", 16'(o_seg), 16'(OFF));
    hold(2'd0, 10); check("post_d0", 16'(o_seg), 16'h79);
    hold(2'd1, 10); check("post_d1", 16'(o_seg), 16'h08);
    hold(2'd2, 10); check("post_d2", 16'(o_seg), 16'(OFF));
    hold(2'd3, 10); check("post_d3", 16'(o_seg), 16'(OFF));
    hold(2'd0, 10); check("post_d0_again", 16'(o_seg), 16'h79);

    // Blank window and reload on a second change
    i_ctrl = 2'd1; tick();
    tick(); check("blank_n1", 16'(o_seg), 16'(OFF));
    tick(); check("blank_n2", 16'(o_seg), 16'(OFF));
    tick(); check("blank_n3_digit", 16'(o_seg), 16'h08);
    i_ctrl = 2'd2; tick();
    i_ctrl = 2'd1; tick(); check("reload_m1", 16'(o_seg), 16'(OFF));
    tick(); check("reload_m2", 16'(o_seg), 16'(OFF));
    tick(); check("reload_m3", 16'(o_seg), 16'(OFF));
    tick(); check("reload_m4_digit", 16'(o_seg), 16'h08);

    // Handshake: no acceptance while pending, ready returns one cycle after boundary
    send(16'h1234);
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_value = 16'hF000 + 16'(i);
      tick();
      check($sformatf("busy_ready_%0d", i), 16'(o_ready), 16'd0);
    end
    i_valid = 1'b0;
    hold(2'd2, 2);
    hold(2'd3, 4);
    check("ready_before_boundary", 16'(o_ready), 16'd0);
    i_ctrl = 2'd0; tick();
    check("ready_after_boundary", 16'(o_ready), 16'd1);
    hold(2'd0, 3); check("hs_d0", 16'(o_seg), 16'h19);
    hold(2'd1, 4); check("hs_d1", 16'(o_seg), 16'h30);
    hold(2'd2, 4); check("hs_d2", 16'(o_seg), 16'h24);
    hold(2'd3, 4); check("hs_d3", 16'(o_seg), 16'h79);
    hold(2'd0, 4);

    // Decode table
    loaded = 16'h1234;
    for (int i = 0; i < 18; i++) begin
      i_lz_en = vecs[i].lz;
      i_dp    = vecs[i].dp;
      if (vecs[i].value != loaded) begin
        load_value(vecs[i].value);
        loaded = vecs[i].value;
      end
      hold(vecs[i].ctrl, 4);
      check($sformatf("vec%0d_seg", i), 16'(o_seg), 16'(vecs[i].seg));
      check($sformatf("vec%0d_dp", i), 16'(o_dp), 16'(vecs[i].odp));
    end

    // Reset mid-frame discards the pending value
    i_lz_en = 1'b0;
    i_dp    = 4'h0;
    send(16'h5555);
    hold(2'd1, 3);
    i_rst  = 1'b1;
    i_ctrl = 2'd0;
    tick();
    check("midrst_seg", 16'(o_seg), 16'(OFF));
    check("midrst_dp", 16'(o_dp), 16'd1);
    check("midrst_ready", 16'(o_ready), 16'd0);
    tick();
    check("midrst_ready2", 16'(o_ready), 16'd0);
    i_rst = 1'b0;
    tick();
    check("midrst_ready_release", 16'(o_ready), 16'd1);
    hold(2'd0, 4); check("midrst_d0", 16'(o_seg), 16'h40);
    hold(2'd1, 4); check("midrst_d1", 16'(o_seg), 16'h40);
    hold(2'd2, 4);
    hold(2'd3, 4); check("midrst_d3", 16'(o_seg), 16'h40);
    hold(2'd0, 4); check("midrst_post_d0", 16'(o_seg), 16'h40);
    check("midrst_post_ready", 16'(o_ready), 16'd1);

    // Blink: phase toggles every BLINK_FRAMES=2 boundaries
    do_reset();
    i_blink = 4'b0010;
    i_dp    = 4'b0010;
    send(16'h1234);
    hold(2'd1, 4);
    hold(2'd2, 4);
    hold(2'd3, 4);
    for (int f = 1; f <= 6; f++) begin
      phase = ((f / 2) % 2) == 1;
      hold(2'd0, 4);
      check($sformatf("blink_f%0d_d0", f), 16'(o_seg), 16'h19);
      check($sformatf("blink_f%0d_d0dp", f), 16'(o_dp), 16'd1);
      hold(2'd1, 4);
      check($sformatf("blink_f%0d_d1", f), 16'(o_seg), phase ? 16'(OFF) : 16'h30);
      check($sformatf("blink_f%0d_d1dp", f), 16'(o_dp), phase ? 16'd1 : 16'd0);
      hold(2'd2, 4);
      check($sformatf("blink_f%0d_d2", f), 16'(o_seg), 16'h24);
      hold(2'd3, 4);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
